pixel_pointop: RTL
==================

# pixel_pointop

Parametrised streaming point-operation unit for the image pipeline; successor to the fixed 8-bit inversion block. It applies a per-frame selectable operation (pass, invert, saturating brightness add, threshold) to every channel of every pixel. Pixels arrive and leave over valid/ready handshakes with full backpressure. Raster position is tracked internally, so start-of-frame, end-of-line and end-of-frame markers travel with each pixel.

## Interface
- DATA_W, 8, bits per channel sample
- CHANNELS, 1, samples per pixel (1 = grey, 3 = RGB)
- IMG_W, 128, pixels per line
- IMG_H, 128, lines per frame
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  0 pass, 1 invert, 2 add-saturate, 3 threshold
- cfg_param  in  DATA_W  add amount (mode 2) or threshold level (mode 3)
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  CHANNELS*DATA_W  input pixel, channel 0 in LSBs
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  CHANNELS*DATA_W  processed pixel
- m_sof / m_eol / m_eof  out  1 each  first pixel of frame / last of line / last of frame
- frame_done  out  1  one-cycle pulse when the m_eof pixel transfers
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0

## Operation
- Per channel, with MAX = 2^DATA_W-1: invert = MAX - x; add = min(x + param, MAX), computed DATA_W+1 wide; threshold = (x >= param) ? MAX : 0; pass = x.
- cfg_mode/cfg_param are sampled into shadow registers on the accepted transfer of the first pixel of a frame (x=0, y=0). Changes mid-frame take effect next frame. Pixels in flight use their own frame's setting.
- Position counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on input transfers. x wraps to 0 and y increments at IMG_W-1. Both wrap to 0 after (IMG_W-1, IMG_H-1).
- Pipeline: stage 1 registers the input pixel, flags and shadow config. Stage 2 registers the operation result and flags.
- Enables: en2 = !v2 || m_ready; en1 = !v1 || en2; s_ready = en1 (combinational from m_ready).
- m_data and the flags hold stable while m_valid && !m_ready.
- Reset values: s_ready 1 after reset release; m_valid 0, m_data 0, m_sof/m_eol/m_eof 0, frame_done 0, frame_cnt 0, x = y = 0, shadow mode 0 (pass), shadow param 0.

## Timing
- Latency: 2 cycles from input transfer to m_valid with m_ready held high. Throughput: 1 pixel/cycle.
- Bubbles on input propagate as m_valid=0 gaps. No pixel is duplicated or dropped under any m_ready pattern.
- frame_done asserts the cycle after the m_eof transfer. frame_cnt increments on the same edge.
- Simultaneous input and output transfers in one cycle are legal at full rate.
- Reset asserted mid-frame clears pipeline and counters immediately (asynchronously). The next accepted pixel is the SOF.

## Configuration
- PIXOP_STATS_EN defined: extra ports stat_min and stat_max (out, DATA_W each) hold the per-frame minimum and maximum of channel 0 of the output. They update on the same edge as frame_done and reset to 0. Internal accumulators restart at the m_sof transfer.
- PIXOP_STATS_EN undefined: these ports and their logic do not exist. All other behaviour is identical.

## Structure
- Package pixop_pkg holds:
  - mode enum (PIXOP_PASS, PIXOP_INV, PIXOP_ADD, PIXOP_THR)
  - frame counter width constant (16)
- Sub-module pixop_alu: combinational single-channel operation, instantiated CHANNELS times in stage 2.

## Test plan
- Reset, mode 1, DATA_W=8, stream a 128x128 ramp (pixel i = i mod 256) with m_ready=1 → output = 255 - input, 2-cycle latency, m_sof on pixel 0, m_eol every 128th pixel, m_eof on pixel 16383, one frame_done, frame_cnt=1.
- Mode 2, param 0x40, inputs 0x00, 0xBF, 0xC0, 0xFF → 0x40, 0xFF, 0xFF, 0xFF.
- Mode 3, param 0x80, inputs 0x7F, 0x80 → 0x00, 0xFF. Switch cfg_mode to 1 at pixel 100 → rest of frame still thresholded, next frame inverted.
- Random m_ready (50%) and random s_valid gaps over 2 frames → output sequence equals reference model, no loss or duplication, m_data stable while stalled.
- CHANNELS=3, mode 1, pixel 0x10_20_30 → 0xEF_DF_CF.
- Assert rst at pixel 5000 of a frame → m_valid=0 and frame_cnt=0 immediately. The next input carries m_sof. With PIXOP_STATS_EN, a full frame of 0x05..0xF0 gives stat_min=0x05, stat_max=0xF0 at frame_done.

Source files
------------

// File: rtl/pixop_pkg.sv
// Shared types and constants for the pixel point-operation unit.
package pixop_pkg;

   typedef enum logic [1:0] {
      PIXOP_PASS = 2'd0,
      PIXOP_INV  = 2'd1,
      PIXOP_ADD  = 2'd2,
      PIXOP_THR  = 2'd3
   } pixop_mode_e;

   localparam int unsigned FRAME_CNT_W = 16;

   // Raster markers that travel alongside each pixel.
   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pixop_flags_t;

endpackage

// File: rtl/pixop_alu.sv
// Single-channel point operation: pass, invert, saturating add, threshold.
module pixop_alu
   import pixop_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  pixop_mode_e       mode_i,
   input  logic [DATA_W-1:0] param_i,
   input  logic [DATA_W-1:0] x_i,
   output logic [DATA_W-1:0] res_o
);

   localparam logic [DATA_W-1:0] MAX = '1;

   logic [DATA_W:0] sum_c;

   // One extra bit on the sum exposes the overflow for saturation.
   always_comb begin
      sum_c = {1'b0, x_i} + {1'b0, param_i};
      res_o = x_i;
      unique case (mode_i)
         PIXOP_PASS: res_o = x_i;
         PIXOP_INV:  res_o = MAX - x_i;
         PIXOP_ADD:  res_o = sum_c[DATA_W] ? MAX : sum_c[DATA_W-1:0];
         PIXOP_THR:  res_o = (x_i >= param_i) ? MAX : '0;
         default:    res_o = x_i;
      endcase
   end

endmodule

// File: rtl/pixel_pointop.sv
// Streaming per-frame point operation with raster markers and frame counting.
// Optional PIXOP_STATS_EN adds per-frame min/max of output channel 0.
module pixel_pointop
   import pixop_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CHANNELS = 1,
   parameter int unsigned IMG_W    = 128,
   parameter int unsigned IMG_H    = 128
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   cfg_mode,
   input  logic [DATA_W-1:0]            cfg_param,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [CHANNELS*DATA_W-1:0]   s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [CHANNELS*DATA_W-1:0]   m_data,
   output logic                         m_sof,
   output logic                         m_eol,
   output logic                         m_eof,
   output logic                         frame_done,
   output logic [FRAME_CNT_W-1:0]       frame_cnt
`ifdef PIXOP_STATS_EN
   ,
   output logic [DATA_W-1:0]            stat_min,
   output logic [DATA_W-1:0]            stat_max
`endif
);

   localparam int unsigned PIX_W = CHANNELS * DATA_W;
   localparam int unsigned X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   pixop_mode_e            mode_q, mode_d;
   logic [DATA_W-1:0]      param_q, param_d;

   logic                   v1_q;
   logic [PIX_W-1:0]       data1_q;
   pixop_flags_t           flags1_q;
   pixop_mode_e            mode1_q;
   logic [DATA_W-1:0]      param1_q;

   logic                   v2_q;
   logic [PIX_W-1:0]       data2_q;
   pixop_flags_t           flags2_q;

   logic                   frame_done_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   logic                   en1_c, en2_c, in_xfer_c, out_xfer_c;
   pixop_flags_t           in_flags_c;
   pixop_mode_e            cur_mode_c;
   logic [DATA_W-1:0]      cur_param_c;
   logic [PIX_W-1:0]       res_c;

   // Stall propagates backwards combinationally so full rate needs no skid buffer.
   assign en2_c      = !v2_q || m_ready;
   assign en1_c      = !v1_q || en2_c;
   assign in_xfer_c  = s_valid && en1_c;
   assign out_xfer_c = v2_q && m_ready;

   // Raster position and config shadow; the SOF pixel itself uses the live config.
   always_comb begin
      in_flags_c.sof = (x_q == '0) && (y_q == '0);
      in_flags_c.eol = (x_q == X_LAST);
      in_flags_c.eof = in_flags_c.eol && (y_q == Y_LAST);
      cur_mode_c     = in_flags_c.sof ? pixop_mode_e'(cfg_mode) : mode_q;
      cur_param_c    = in_flags_c.sof ? cfg_param : param_q;
      x_d            = x_q;
      y_d            = y_q;
      mode_d         = mode_q;
      param_d        = param_q;
      if (in_xfer_c) begin
         mode_d  = cur_mode_c;
         param_d = cur_param_c;
         if (in_flags_c.eol) begin
            x_d = '0;
            y_d = in_flags_c.eof ? '0 : y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pixop_alu #(
         .DATA_W (DATA_W)
      ) u_alu (
         .mode_i  (mode1_q),
         .param_i (param1_q),
         .x_i     (data1_q[c*DATA_W +: DATA_W]),
         .res_o   (res_c[c*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q          <= '0;
         y_q          <= '0;
         mode_q       <= PIXOP_PASS;
         param_q      <= '0;
         v1_q         <= 1'b0;
         data1_q      <= '0;
         flags1_q     <= '0;
         mode1_q      <= PIXOP_PASS;
         param1_q     <= '0;
         v2_q         <= 1'b0;
         data2_q      <= '0;
         flags2_q     <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         mode_q  <= mode_d;
         param_q <= param_d;
         if (en1_c) begin
            v1_q <= s_valid;
            if (s_valid) begin
               data1_q  <= s_data;
               flags1_q <= in_flags_c;
               mode1_q  <= cur_mode_c;
               param1_q <= cur_param_c;
            end
         end
         if (en2_c) begin
            v2_q <= v1_q;
            if (v1_q) begin
               data2_q  <= res_c;
               flags2_q <= flags1_q;
            end
         end
         frame_done_q <= out_xfer_c && flags2_q.eof;
         if (out_xfer_c && flags2_q.eof) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
         end
      end
   end

   assign m_valid    = v2_q;
   assign m_data     = data2_q;
   assign m_sof      = flags2_q.sof;
   assign m_eol      = flags2_q.eol;
   assign m_eof      = flags2_q.eof;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign s_ready    = en1_c;

`ifdef PIXOP_STATS_EN
   logic [DATA_W-1:0] ch0_c, min_new_c, max_new_c;
   logic [DATA_W-1:0] min_acc_q, max_acc_q, stat_min_q, stat_max_q;

   // Running extremes restart on the SOF pixel; the EOF pixel is folded in before publishing.
   always_comb begin
      ch0_c     = data2_q[DATA_W-1:0];
      min_new_c = (flags2_q.sof || (ch0_c < min_acc_q)) ? ch0_c : min_acc_q;
      max_new_c = (flags2_q.sof || (ch0_c > max_acc_q)) ? ch0_c : max_acc_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_acc_q  <= '0;
         max_acc_q  <= '0;
         stat_min_q <= '0;
         stat_max_q <= '0;
      end else if (out_xfer_c) begin
         min_acc_q <= min_new_c;
         max_acc_q <= max_new_c;
         if (flags2_q.eof) begin
            stat_min_q <= min_new_c;
            stat_max_q <= max_new_c;
         end
      end
   end

   assign stat_min = stat_min_q;
   assign stat_max = stat_max_q;
`endif

endmodule
